// File: rtl/vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// vga_timing_ctrl
//
// Purpose:
//   Raster timing for a VGA-style display. A horizontal pixel counter is
//   chained to a vertical line counter. Each axis carries a small phase FSM
//   (ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE). The FSMs drive the
//   registered, glitch-free hsync/vsync/video_on outputs.
//
// Ports:
//   clk        in   system clock (single domain)
//   reset      in   synchronous active-high reset; overrides pix_en
//   pix_en     in   pixel enable; state advances only on edges where it is 1
//   x          out  [10:0] horizontal count, 0..H_TOTAL-1
//   y          out  [10:0] vertical count, 0..V_TOTAL-1
//   video_on   out  registered, 1 while both axes are in ACTIVE
//   hsync      out  registered, active low while the horizontal phase is SYNC
//   vsync      out  registered, active low while the vertical phase is SYNC
//   line_end   out  combinational strobe, pix_en on the last pixel of a line
//   frame_end  out  combinational strobe, line_end on the last line of a frame
//
// Every phase width must be at least 1, and each axis total must be <= 2047.
// ---------------------------------------------------------------------------
module vga_timing_ctrl #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic        line_end,
    output logic        frame_end
);

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_e;

    // Phase boundaries per axis; index 0 is horizontal, index 1 is vertical.
    localparam logic [1:0][10:0] FP_START = {
        11'(V_ACTIVE),
        11'(H_ACTIVE)
    };
    localparam logic [1:0][10:0] SYNC_START = {
        11'(V_ACTIVE + V_FP),
        11'(H_ACTIVE + H_FP)
    };
    localparam logic [1:0][10:0] BP_START = {
        11'(V_ACTIVE + V_FP + V_SYNC),
        11'(H_ACTIVE + H_FP + H_SYNC)
    };
    localparam logic [1:0][10:0] LAST = {
        11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1),
        11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1)
    };

    // The phase moves on the same edge the counter lands on a boundary, so it
    // is decided from the counter's next value rather than its current one.
    function automatic phase_e phase_next(
        input phase_e      cur,
        input logic [10:0] cnt_next,
        input logic [10:0] fp_start,
        input logic [10:0] sync_start,
        input logic [10:0] bp_start
    );
        phase_e nxt;
        nxt = cur;
        case (cur)
            ACTIVE:  if (cnt_next == fp_start)   nxt = FRONT;
            FRONT:   if (cnt_next == sync_start) nxt = SYNC;
            SYNC:    if (cnt_next == bp_start)   nxt = BACK;
            BACK:    if (cnt_next == 11'd0)      nxt = ACTIVE;
            default: nxt = ACTIVE;
        endcase
        return nxt;
    endfunction

    // Per-axis advance: horizontal on each enabled pixel, vertical once per line.
    logic [1:0] adv;
    assign adv[0] = pix_en;
    assign adv[1] = line_end;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            logic [10:0] cnt_q;
            logic [10:0] cnt_d;
            phase_e      phase_q;
            phase_e      phase_d;

            always_comb begin
                cnt_d   = cnt_q;
                phase_d = phase_q;
                if (adv[gi]) begin
                    cnt_d   = (cnt_q == LAST[gi]) ? 11'd0 : cnt_q + 11'd1;
                    phase_d = phase_next(phase_q, cnt_d, FP_START[gi],
                                         SYNC_START[gi], BP_START[gi]);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q   <= 11'd0;
                    phase_q <= ACTIVE;
                end else begin
                    cnt_q   <= cnt_d;
                    phase_q <= phase_d;
                end
            end
        end
    endgenerate

    // Outputs are registered from the next-state phases so that they change
    // on exactly the same edge as the counters (no one-pixel lag).
    logic hsync_q;
    logic hsync_d;
    logic vsync_q;
    logic vsync_d;
    logic video_on_q;
    logic video_on_d;

    always_comb begin
        hsync_d    = (g_axis[0].phase_d != SYNC);
        vsync_d    = (g_axis[1].phase_d != SYNC);
        video_on_d = (g_axis[0].phase_d == ACTIVE) && (g_axis[1].phase_d == ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            video_on_q <= 1'b1;
        end else begin
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            video_on_q <= video_on_d;
        end
    end

    assign x         = g_axis[0].cnt_q;
    assign y         = g_axis[1].cnt_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign video_on  = video_on_q;
    assign line_end  = pix_en && (g_axis[0].cnt_q == LAST[0]);
    assign frame_end = line_end && (g_axis[1].cnt_q == LAST[1]);

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_ctrl
//
// Two instances share one clock. Instance A uses the standard 800x525
// geometry and covers line-level behaviour. Instance B uses a reduced
// 32x19 geometry so that whole frames fit in a short run. A reference model
// counts enabled pixels since reset. From that count it derives every
// output with plain div/mod arithmetic, and the outputs are compared on
// every falling edge. Directed literal checks pin particular points.
// ---------------------------------------------------------------------------
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: standard geometry ----------------
    logic        reset_a  = 1'b1;
    logic        pix_en_a = 1'b1;
    logic [10:0] x_a, y_a;
    logic        von_a, hs_a, vs_a, le_a, fe_a;

    vga_timing_ctrl dut_a (
        .clk       (clk),
        .reset     (reset_a),
        .pix_en    (pix_en_a),
        .x         (x_a),
        .y         (y_a),
        .video_on  (von_a),
        .hsync     (hs_a),
        .vsync     (vs_a),
        .line_end  (le_a),
        .frame_end (fe_a)
    );

    // ---------------- instance B: reduced geometry ----------------
    localparam int BHA = 20, BHF = 3, BHS = 5, BHB = 4;   // 32 pixels per line
    localparam int BVA = 12, BVF = 2, BVS = 2, BVB = 3;   // 19 lines per frame
    localparam int B_FRAME = 32 * 19;                     // 608 clocks

    logic        reset_b  = 1'b1;
    logic        pix_en_b = 1'b0;
    logic [10:0] x_b, y_b;
    logic        von_b, hs_b, vs_b, le_b, fe_b;

    vga_timing_ctrl #(
        .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
        .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB)
    ) dut_b (
        .clk       (clk),
        .reset     (reset_b),
        .pix_en    (pix_en_b),
        .x         (x_b),
        .y         (y_b),
        .video_on  (von_b),
        .hsync     (hs_b),
        .vsync     (vs_b),
        .line_end  (le_b),
        .frame_end (fe_b)
    );

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int x;
        int y;
        int hs;
        int vs;
        int von;
        int le;
        int fe;
    } exp_t;

    // Everything follows from the count of enabled pixels since reset.
    function automatic exp_t model(input longint t, input int en,
                                   input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb);
        exp_t m;
        int   ht;
        int   vt;
        ht    = ha + hf + hsw + hb;
        vt    = va + vf + vsw + vb;
        m.x   = int'(t % longint'(ht));
        m.y   = int'((t / longint'(ht)) % longint'(vt));
        m.hs  = (m.x >= ha + hf && m.x < ha + hf + hsw) ? 0 : 1;
        m.vs  = (m.y >= va + vf && m.y < va + vf + vsw) ? 0 : 1;
        m.von = (m.x < ha && m.y < va) ? 1 : 0;
        m.le  = (en != 0 && m.x == ht - 1) ? 1 : 0;
        m.fe  = (m.le != 0 && m.y == vt - 1) ? 1 : 0;
        return m;
    endfunction

    longint tick_a = 0, tick_b = 0;
    bit     valid_a = 1'b0, valid_b = 1'b0;

    always @(posedge clk) begin
        if (reset_a) begin
            tick_a  <= 0;
            valid_a <= 1'b1;
        end else if (pix_en_a) begin
            tick_a <= tick_a + 1;
        end
        if (reset_b) begin
            tick_b  <= 0;
            valid_b <= 1'b1;
        end else if (pix_en_b) begin
            tick_b <= tick_b + 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        exp_t ma;
        exp_t mb;
        if (valid_a) begin
            ma = model(tick_a, int'(pix_en_a), 640, 16, 96, 48, 480, 10, 2, 33);
            check("A.x",         int'(x_a),   ma.x);
            check("A.y",         int'(y_a),   ma.y);
            check("A.hsync",     int'(hs_a),  ma.hs);
            check("A.vsync",     int'(vs_a),  ma.vs);
            check("A.video_on",  int'(von_a), ma.von);
            check("A.line_end",  int'(le_a),  ma.le);
            check("A.frame_end", int'(fe_a),  ma.fe);
        end
        if (valid_b) begin
            mb = model(tick_b, int'(pix_en_b), BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB);
            check("B.x",         int'(x_b),   mb.x);
            check("B.y",         int'(y_b),   mb.y);
            check("B.hsync",     int'(hs_b),  mb.hs);
            check("B.vsync",     int'(vs_b),  mb.vs);
            check("B.video_on",  int'(von_b), mb.von);
            check("B.line_end",  int'(le_b),  mb.le);
            check("B.frame_end", int'(fe_b),  mb.fe);
        end
    end

    // Advance n clock edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int k;
        int found;
        int fe_count;
        int fe_at [3];

        // Reset for two clocks with pix_en held high.
        step(2);
        $display("txn A reset: x=%0d y=%0d hs=%0d vs=%0d von=%0d", x_a, y_a, hs_a, vs_a, von_a);
        check("A.rst_x", int'(x_a), 0);
        check("A.rst_y", int'(y_a), 0);
        check("A.rst_hsync", int'(hs_a), 1);
        check("A.rst_vsync", int'(vs_a), 1);
        check("A.rst_video_on", int'(von_a), 1);
        check("A.rst_line_end", int'(le_a), 0);
        check("A.rst_frame_end", int'(fe_a), 0);

        reset_a = 1'b0;
        step(1);
        $display("txn A release: x=%0d", x_a);
        check("A.after_release_x", int'(x_a), 1);

        // Horizontal sweep across the phase boundaries.
        step(638);
        check("A.x639_video_on", int'(von_a), 1);
        step(1);
        $display("txn A x=%0d von=%0d", x_a, von_a);
        check("A.x640_video_on", int'(von_a), 0);
        step(15);
        check("A.x655_hsync", int'(hs_a), 1);
        step(1);
        $display("txn A x=%0d hs=%0d", x_a, hs_a);
        check("A.x656_hsync", int'(hs_a), 0);
        step(95);
        check("A.x751_hsync", int'(hs_a), 0);
        step(1);
        $display("txn A x=%0d hs=%0d", x_a, hs_a);
        check("A.x752_hsync", int'(hs_a), 1);
        step(47);
        $display("txn A x=%0d le=%0d", x_a, le_a);
        check("A.x799_x", int'(x_a), 799);
        check("A.x799_line_end", int'(le_a), 1);
        step(1);
        $display("txn A wrap: x=%0d y=%0d", x_a, y_a);
        check("A.wrap_x", int'(x_a), 0);
        check("A.wrap_y", int'(y_a), 1);

        // Full-rate line period: line_end after 799 more edges.
        found = -1;
        for (int i = 0; i < 1000; i++) begin
            if (le_a) begin
                found = i;
                break;
            end
            step(1);
        end
        $display("txn A line period (full rate): %0d", found + 1);
        check("A.line_period_full", found + 1, 800);
        step(1);    // consume the line_end edge -> (0,2)

        // pix_en on every 4th clock: line period is 3200 clocks.
        found = -1;
        for (k = 0; k < 4000; k++) begin
            pix_en_a = ((k % 4) == 3);
            #1;
            if (le_a) begin
                found = k;
                break;
            end
            step(1);
        end
        $display("txn A line period (1/4 rate): %0d", found + 1);
        check("A.line_period_quarter", found + 1, 3200);
        step(1);
        pix_en_a = 1'b1;
        check("A.after_quarter_y", int'(y_a), 3);

        // Mid-line reset with pix_en low.
        step(700);
        check("A.pre_reset_x", int'(x_a), 700);
        pix_en_a = 1'b0;
        reset_a  = 1'b1;
        step(1);
        $display("txn A mid reset: x=%0d y=%0d hs=%0d vs=%0d", x_a, y_a, hs_a, vs_a);
        check("A.midrst_x", int'(x_a), 0);
        check("A.midrst_y", int'(y_a), 0);
        check("A.midrst_hsync", int'(hs_a), 1);
        check("A.midrst_vsync", int'(vs_a), 1);
        check("A.midrst_video_on", int'(von_a), 1);
        reset_a = 1'b0;

        // Instance B: reset with pix_en low, then three full frames.
        step(1);
        reset_b  = 1'b0;
        pix_en_b = 1'b1;
        fe_count = 0;
        for (int c = 0; c < 3 * B_FRAME; c++) begin
            if (fe_b) begin
                if (fe_count < 3) fe_at[fe_count] = c;
                fe_count++;
                $display("txn B frame_end at cycle %0d (x=%0d y=%0d)", c, x_b, y_b);
            end
            if (c == 352) check("B.y11_video_on", int'(von_b), 1);
            if (c == 383) check("B.x31y11_video_on", int'(von_b), 0);
            if (c == 384) check("B.y12_video_on", int'(von_b), 0);
            if (c == 447) check("B.y13_vsync", int'(vs_b), 1);
            if (c == 448) check("B.y14_vsync", int'(vs_b), 0);
            if (c == 511) check("B.y15_vsync", int'(vs_b), 0);
            if (c == 512) check("B.y16_vsync", int'(vs_b), 1);
            step(1);
        end
        check("B.frame_end_count", fe_count, 3);
        if (fe_count >= 3) begin
            check("B.first_frame_end", fe_at[0], 607);
            check("B.frame_spacing_1", fe_at[1] - fe_at[0], B_FRAME);
            check("B.frame_spacing_2", fe_at[2] - fe_at[1], B_FRAME);
        end
        $display("txn B after 3 frames: x=%0d y=%0d", x_b, y_b);
        check("B.wrap_x", int'(x_b), 0);
        check("B.wrap_y", int'(y_b), 0);
        check("B.wrap_hsync", int'(hs_b), 1);
        check("B.wrap_vsync", int'(vs_b), 1);
        check("B.wrap_video_on", int'(von_b), 1);

        // Instance B: reset inside the vertical sync region with pix_en low.
        step(15 * 32 + 25);
        check("B.pre_reset_y", int'(y_b), 15);
        check("B.pre_reset_vsync", int'(vs_b), 0);
        pix_en_b = 1'b0;
        reset_b  = 1'b1;
        step(1);
        $display("txn B mid reset: x=%0d y=%0d vs=%0d", x_b, y_b, vs_b);
        check("B.midrst_x", int'(x_b), 0);
        check("B.midrst_y", int'(y_b), 0);
        check("B.midrst_vsync", int'(vs_b), 1);
        check("B.midrst_video_on", int'(von_b), 1);
        reset_b = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
